// File: rtl/vc_input_queue.sv
// vc_input_queue
//   Router input-port queue. V virtual channels, each a 2^B-entry FIFO of
//   {dest mask, flit}. One flit is in service at a time: it is popped
//   round-robin across non-empty VCs, presented to the switch allocator
//   with its remaining destination mask, and retired once every requested
//   port has been granted. Multicast may be granted piecemeal. A zero mask
//   drops the flit. The next pop overlaps the finishing cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   flit_in_wr        write strobe for flit_in/dest_in into VC flit_in_vc
//   flit_in_vc        target VC (out of range -> write ignored, error set)
//   flit_in, dest_in  flit payload and destination port mask
//   dest_port_req     ports still requested by the flit in service
//   grant_dest_port   ports granted this cycle
//   flit_to_crossbar  flit in service (holds last value when idle)
//   vc_out            VC of the flit in service
//   flit_rel          per-VC credit pulse in the pop cycle
//   overflow_err      sticky: write to a full VC or to a bad VC index

// Per-VC FIFO: registered read data, valid the cycle after rd_i.
module vc_input_queue_fifo #(
   parameter int W = 8,
   parameter int B = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_i,
   input  logic [W-1:0] wdata_i,
   input  logic         rd_i,
   output logic [W-1:0] rdata_o,
   output logic         ne_o,
   output logic         full_o
);
   localparam int DEPTH = 2**B;

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;
   logic [B-1:0] wp_q, rp_q;
   logic [B:0]   cnt_q;
   logic         wr_ok;

   assign full_o  = (cnt_q == (B+1)'(DEPTH));
   assign ne_o    = (cnt_q != '0);
   assign wr_ok   = wr_i && !full_o;
   assign rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok) wp_q <= wp_q + 1'b1;
         if (rd_i)  rp_q <= rp_q + 1'b1;
         case ({wr_ok, rd_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   // Pop only happens when non-empty, so the read never targets the slot
   // being written in the same cycle.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wp_q] <= wdata_i;
      if (rd_i)  rdata_q     <= mem_q[rp_q];
   end
endmodule

module vc_input_queue #(
   parameter int FW  = 64,
   parameter int P   = 7,
   parameter int V   = 2,
   parameter int VCW = 1,
   parameter int B   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flit_in_wr,
   input  logic [VCW-1:0] flit_in_vc,
   input  logic [FW-1:0]  flit_in,
   input  logic [P-1:0]   dest_in,
   output logic [P-1:0]   dest_port_req,
   input  logic [P-1:0]   grant_dest_port,
   output logic [FW-1:0]  flit_to_crossbar,
   output logic [VCW-1:0] vc_out,
   output logic [V-1:0]   flit_rel,
   output logic           overflow_err
);
   localparam int EW = P + FW;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SEND} state_e;

   state_e               state_q, state_d;
   logic [V-1:0]         wr_v, rd_v, ne_v, full_v;
   logic [V-1:0][EW-1:0] rdata_v;
   logic [EW-1:0]        head;
   logic [P-1:0]         rem_q, rem_d, req;
   logic [FW-1:0]        hold_q, hold_d, xbar;
   logic [VCW-1:0]       vc_q, rr_q, sel, idx;
   logic                 vc_ok, any_ne, fin, pop, ovf_q, ovf;

   assign vc_ok = (32'(flit_in_vc) < V);

   for (genvar v = 0; v < V; v++) begin : g_vc
      assign wr_v[v] = flit_in_wr && vc_ok && (flit_in_vc == VCW'(v));
      vc_input_queue_fifo #(.W(EW), .B(B)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_i    (wr_v[v]),
         .wdata_i ({dest_in, flit_in}),
         .rd_i    (rd_v[v]),
         .rdata_o (rdata_v[v]),
         .ne_o    (ne_v[v]),
         .full_o  (full_v[v])
      );
   end

   assign ovf = flit_in_wr && (!vc_ok || full_v[flit_in_vc]);

   // Round-robin: first non-empty VC after the last one served.
   always_comb begin
      sel    = rr_q;
      idx    = '0;
      any_ne = 1'b0;
      for (int k = 1; k <= V; k++) begin
         idx = VCW'((int'(rr_q) + k) % V);
         if (!any_ne && ne_v[idx]) begin
            any_ne = 1'b1;
            sel    = idx;
         end
      end
   end

   assign head = rdata_v[vc_q];

   // ISSUE shows the FIFO read register directly; SEND shows the hold copy.
   // Grant only feeds next state, never dest_port_req.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      req     = '0;
      xbar    = hold_q;
      fin     = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_ISSUE: begin
            req     = head[EW-1 -: P];
            xbar    = head[FW-1:0];
            hold_d  = head[FW-1:0];
            rem_d   = head[EW-1 -: P] & ~grant_dest_port;
            fin     = (rem_d == '0);
            state_d = S_SEND;
         end
         S_SEND: begin
            req   = rem_q;
            rem_d = rem_q & ~grant_dest_port;
            fin   = (rem_d == '0);
         end
         default: state_d = S_IDLE;
      endcase
      pop = any_ne && ((state_q == S_IDLE) || fin);
      if (pop)      state_d = S_ISSUE;
      else if (fin) state_d = S_IDLE;
   end

   assign rd_v             = pop ? (V'(1) << sel) : '0;
   assign flit_rel         = rd_v;
   assign dest_port_req    = req;
   assign flit_to_crossbar = xbar;
   assign vc_out           = vc_q;
   assign overflow_err     = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         hold_q  <= '0;
         vc_q    <= '0;
         rr_q    <= VCW'(V-1);
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         hold_q  <= hold_d;
         if (pop) begin
            vc_q <= sel;
            rr_q <= sel;
         end
         if (ovf) ovf_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vc_input_queue.sv
// Randomised + directed bench for vc_input_queue against a queue-based
// transaction model: per-VC flit queues, one in-service flit with the set
// of ports it still needs, round-robin choice among non-empty VCs.
module tb_vc_input_queue;
   localparam int FW    = 64;
   localparam int P     = 7;
   localparam int V     = 2;
   localparam int VCW   = 1;
   localparam int B     = 4;
   localparam int DEPTH = 2**B;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flit_in_wr;
   logic [VCW-1:0] flit_in_vc;
   logic [FW-1:0]  flit_in;
   logic [P-1:0]   dest_in;
   logic [P-1:0]   dest_port_req;
   logic [P-1:0]   grant_dest_port;
   logic [FW-1:0]  flit_to_crossbar;
   logic [VCW-1:0] vc_out;
   logic [V-1:0]   flit_rel;
   logic           overflow_err;

   vc_input_queue #(.FW(FW), .P(P), .V(V), .VCW(VCW), .B(B)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flit_in_wr       (flit_in_wr),
      .flit_in_vc       (flit_in_vc),
      .flit_in          (flit_in),
      .dest_in          (dest_in),
      .dest_port_req    (dest_port_req),
      .grant_dest_port  (grant_dest_port),
      .flit_to_crossbar (flit_to_crossbar),
      .vc_out           (vc_out),
      .flit_rel         (flit_rel),
      .overflow_err     (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [P-1:0]  d;
      logic [FW-1:0] f;
   } ent_t;

   ent_t          mq [V][$];
   int            m_rr;
   bit            m_svc;
   logic [P-1:0]  m_rem;
   logic [FW-1:0] m_xbar;
   int            m_vc;
   bit            m_ovf;
   int            acc_cnt [V];
   int            rel_cnt [V];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= V; k++) begin
         int i;
         i = (m_rr + k) % V;
         if (mq[i].size() > 0) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < V; v++) begin
         mq[v].delete();
         acc_cnt[v] = 0;
         rel_cnt[v] = 0;
      end
      m_rr = V - 1; m_svc = 0; m_rem = '0; m_xbar = '0; m_vc = 0; m_ovf = 0;
   endtask

   // One clock cycle: entered just after a rising edge, drives inputs,
   // checks outputs at the falling edge, then advances the model.
   task automatic cyc(input bit wr, input int vc, input logic [P-1:0] dst,
                      input logic [P-1:0] gnt);
      logic [FW-1:0] f;
      logic [V-1:0]  exp_rel;
      bit            elig, wfull;
      int            pv;
      ent_t          e;
      f = {$urandom(), $urandom()};
      flit_in_wr = wr; flit_in_vc = VCW'(vc); flit_in = f; dest_in = dst;
      grant_dest_port = gnt;

      elig    = !m_svc || ((m_rem & ~gnt) == '0);
      pv      = elig ? pick() : -1;
      exp_rel = '0;
      if (pv >= 0) exp_rel[pv] = 1'b1;

      @(negedge clk);
      chk("dest_port_req", 64'(dest_port_req), 64'(m_svc ? m_rem : '0));
      chk("flit_to_crossbar", flit_to_crossbar, m_xbar);
      chk("vc_out", 64'(vc_out), 64'(m_vc));
      chk("flit_rel", 64'(flit_rel), 64'(exp_rel));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      for (int v = 0; v < V; v++) if (flit_rel[v]) rel_cnt[v]++;

      wfull = wr && ((vc >= V) || (mq[vc].size() == DEPTH));
      if (pv >= 0) begin
         e = mq[pv].pop_front();
         m_svc = 1; m_rem = e.d; m_xbar = e.f; m_vc = pv; m_rr = pv;
      end else if (elig) begin
         m_svc = 0;
      end else begin
         m_rem = m_rem & ~gnt;
      end
      if (wr) begin
         if (wfull) m_ovf = 1;
         else begin
            e.d = dst; e.f = f;
            mq[vc].push_back(e);
            acc_cnt[vc]++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      flit_in_wr = 1'b0; flit_in_vc = '0; flit_in = '0; dest_in = '0;
      grant_dest_port = '0;
      #1;
      chk("rst dest_port_req", 64'(dest_port_req), 64'd0);
      chk("rst flit_to_crossbar", flit_to_crossbar, 64'd0);
      chk("rst vc_out", 64'(vc_out), 64'd0);
      chk("rst flit_rel", 64'(flit_rel), 64'd0);
      chk("rst overflow_err", 64'(overflow_err), 64'd0);
      model_reset();
      repeat (ncyc) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic [P-1:0] gnt);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, gnt);
   endtask

   task automatic credit_check(input string tag);
      for (int v = 0; v < V; v++) chk(tag, 64'(rel_cnt[v]), 64'(acc_cnt[v]));
   endtask

   initial begin
      do_reset(2);

      // Unicast on VC0, grant arriving in the ISSUE cycle.
      cyc(1, 0, 7'b0000100, 7'b0000100);
      idle(3, 7'b0000100);

      // Multicast granted piecemeal: 0000001, nothing, then 0010010.
      cyc(1, 0, 7'b0010011, '0);
      cyc(0, 0, '0, '0);
      cyc(0, 0, '0, 7'b0000001);
      cyc(0, 0, '0, '0);
      cyc(0, 0, '0, 7'b0010010);
      idle(2, '0);

      // Round-robin: stall on a VC0 flit, preload 3+3, then grant all.
      cyc(1, 0, 7'b1000000, '0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 7'(1 << i), '0);
         cyc(1, 1, 7'(2 << i), '0);
      end
      idle(10, '1);
      credit_check("credits rr");

      // Zero-mask drop followed by a real unicast.
      cyc(1, 0, 7'b0000000, '1);
      cyc(1, 0, 7'b0000001, '1);
      idle(4, '1);

      // Overflow: stall on VC0, 17 writes to VC1, then drain.
      cyc(1, 0, 7'b0000001, '0);
      for (int i = 0; i < 17; i++) cyc(1, 1, 7'b0000010, '0);
      chk("ovf after 17th write", 64'(overflow_err), 64'd1);
      idle(25, '1);
      credit_check("credits ovf");

      // Reset while SEND waits on port 4 with two flits queued.
      cyc(1, 0, 7'b0010001, '0);
      cyc(1, 0, 7'b0000001, '0);
      cyc(1, 0, 7'b0000010, 7'b0000001);
      cyc(0, 0, '0, '0);
      do_reset(2);
      idle(5, '1);

      // Random traffic with periodic stalls so VCs fill and overflow.
      for (int i = 0; i < 3000; i++) begin
         bit            wr;
         int            vc;
         logic [P-1:0]  dst, gnt;
         wr  = ($urandom % 2) == 0;
         vc  = $urandom % V;
         dst = (($urandom % 8) == 0) ? '0 : P'($urandom);
         if (((i / 150) % 4) == 3)       gnt = '0;
         else if (($urandom % 3) == 0)   gnt = '1;
         else                            gnt = P'($urandom);
         cyc(wr, vc, dst, gnt);
      end
      idle(60, '1);
      credit_check("credits random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
